// File: rtl/spu_pipe_pkg.sv
// Shared types, constants and helpers for the fetch/decode lane pipeline.
package spu_pipe_pkg;

    localparam logic [31:0] SPU_NOP = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } lane_entry_t;

    // Returns v+1, pinned at the all-ones value of a w-bit counter (w <= 63).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/if_id_lane.sv
// One issue lane: DEPTH-stage {valid, instr} chain plus saturating stall/flush counters.
module if_id_lane
    import spu_pipe_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 1,
    parameter logic [WIDTH-1:0]   NOP_INSTR = WIDTH'(SPU_NOP),
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             valid_in,
    input  logic             st_e,
    input  logic             fl_e,
    input  logic             clear_cnt,
    output logic [WIDTH-1:0] instr_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] instr;
    } stage_t;

    stage_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || fl_e) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe[k] <= '{valid: 1'b0, instr: NOP_INSTR};
            end
        end else if (!st_e) begin
            pipe[0] <= '{valid: valid_in, instr: instr_in};
            for (int k = 1; k < DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    // Flush wins over stall, so a cycle with both only bumps flush_cnt.
    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (fl_e) begin
            flush_cnt <= CNT_W'(sat_inc(64'(flush_cnt), CNT_W));
        end else if (st_e) begin
            stall_cnt <= CNT_W'(sat_inc(64'(stall_cnt), CNT_W));
        end
    end

    assign instr_out = pipe[DEPTH-1].instr;
    assign valid_out = pipe[DEPTH-1].valid;

endmodule

// File: rtl/if_id_lane_pipe.sv
// Multi-lane IF/ID register: per-lane chains with optional lockstep stall/flush coupling.
module if_id_lane_pipe
    import spu_pipe_pkg::*;
#(
    parameter int               LANES     = 2,
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter bit               LOCKSTEP  = 1'b0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(SPU_NOP),
    parameter int               CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] instr_in,
    input  logic [LANES-1:0]       valid_in,
    input  logic [LANES-1:0]       stall,
    input  logic [LANES-1:0]       flush,
    input  logic                   clear_cnt,
    output logic [LANES*WIDTH-1:0] instr_out,
    output logic [LANES-1:0]       valid_out,
    output logic [LANES*CNT_W-1:0] stall_cnt,
    output logic [LANES*CNT_W-1:0] flush_cnt
);

    logic [LANES-1:0] st_e;
    logic [LANES-1:0] fl_e;
    logic             fl_acc;

    // In lockstep, any stall freezes every lane and a flush kills its lane and all younger ones.
    always_comb begin
        st_e   = stall;
        fl_e   = flush;
        fl_acc = 1'b0;
        if (LOCKSTEP) begin
            st_e = {LANES{|stall}};
            for (int i = 0; i < LANES; i++) begin
                fl_acc  = fl_acc | flush[i];
                fl_e[i] = fl_acc;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if_id_lane #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .NOP_INSTR (NOP_INSTR),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .instr_in  (instr_in[i*WIDTH +: WIDTH]),
            .valid_in  (valid_in[i]),
            .st_e      (st_e[i]),
            .fl_e      (fl_e[i]),
            .clear_cnt (clear_cnt),
            .instr_out (instr_out[i*WIDTH +: WIDTH]),
            .valid_out (valid_out[i]),
            .stall_cnt (stall_cnt[i*CNT_W +: CNT_W]),
            .flush_cnt (flush_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_if_id_lane_pipe.sv
// Directed bench for if_id_lane_pipe across three configurations sharing one clock.
module tb_if_id_lane_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A: LANES=2, DEPTH=1, CNT_W=4, NOP=0
    logic        a_rst, a_clr;
    logic [63:0] a_in, a_out;
    logic [1:0]  a_vin, a_st, a_fl, a_vout;
    logic [7:0]  a_sc, a_fc;

    if_id_lane_pipe #(.LANES(2), .WIDTH(32), .DEPTH(1), .LOCKSTEP(1'b0),
                      .NOP_INSTR(32'h0), .CNT_W(4)) u_a (
        .clk(clk), .reset(a_rst), .instr_in(a_in), .valid_in(a_vin), .stall(a_st),
        .flush(a_fl), .instr_out(a_out), .valid_out(a_vout), .stall_cnt(a_sc),
        .flush_cnt(a_fc), .clear_cnt(a_clr));

    // B: LANES=2, DEPTH=3, CNT_W=16
    logic        b_rst, b_clr;
    logic [63:0] b_in, b_out;
    logic [1:0]  b_vin, b_st, b_fl, b_vout;
    logic [31:0] b_sc, b_fc;

    if_id_lane_pipe #(.LANES(2), .WIDTH(32), .DEPTH(3), .LOCKSTEP(1'b0),
                      .NOP_INSTR(32'h0), .CNT_W(16)) u_b (
        .clk(clk), .reset(b_rst), .instr_in(b_in), .valid_in(b_vin), .stall(b_st),
        .flush(b_fl), .instr_out(b_out), .valid_out(b_vout), .stall_cnt(b_sc),
        .flush_cnt(b_fc), .clear_cnt(b_clr));

    // C: LANES=4, DEPTH=2, lockstep, NOP=0x13, CNT_W=8
    logic         c_rst, c_clr;
    logic [127:0] c_in, c_out;
    logic [3:0]   c_vin, c_st, c_fl, c_vout;
    logic [31:0]  c_sc, c_fc;

    if_id_lane_pipe #(.LANES(4), .WIDTH(32), .DEPTH(2), .LOCKSTEP(1'b1),
                      .NOP_INSTR(32'h13), .CNT_W(8)) u_c (
        .clk(clk), .reset(c_rst), .instr_in(c_in), .valid_in(c_vin), .stall(c_st),
        .flush(c_fl), .instr_out(c_out), .valid_out(c_vout), .stall_cnt(c_sc),
        .flush_cnt(c_fc), .clear_cnt(c_clr));

    localparam logic [31:0] C_NOP = 32'h13;

    function automatic logic [31:0] cval(input int t, input int i);
        return 32'(t * 256 + i);
    endfunction

    function automatic logic [127:0] cvec(input int t);
        return {cval(t, 3), cval(t, 2), cval(t, 1), cval(t, 0)};
    endfunction

    typedef struct {
        logic [1:0]  st, fl, vin;
        logic        clr;
        logic [63:0] din;
        logic [63:0] eout;
        logic [1:0]  ev;
        logic [7:0]  esc, efc;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          b_exp1 [10];
        logic [31:0] b_lane1;

        tbl[0] = '{2'b00, 2'b00, 2'b11, 1'b0, {32'hB2, 32'hA1}, {32'hB2, 32'hA1}, 2'b11, 8'h00, 8'h00};
        tbl[1] = '{2'b01, 2'b01, 2'b11, 1'b0, {32'hC3, 32'hC4}, {32'hC3, 32'h00}, 2'b10, 8'h00, 8'h01};
        tbl[2] = '{2'b10, 2'b00, 2'b11, 1'b0, {32'hD4, 32'hD5}, {32'hC3, 32'hD5}, 2'b11, 8'h10, 8'h01};
        tbl[3] = '{2'b00, 2'b00, 2'b01, 1'b0, {32'hE6, 32'hE7}, {32'hE6, 32'hE7}, 2'b01, 8'h10, 8'h01};
        tbl[4] = '{2'b11, 2'b10, 2'b11, 1'b0, {32'hF8, 32'hF9}, {32'h00, 32'hE7}, 2'b01, 8'h11, 8'h11};
        tbl[5] = '{2'b01, 2'b00, 2'b11, 1'b1, {32'h11, 32'h12}, {32'h11, 32'hE7}, 2'b11, 8'h00, 8'h00};
        b_exp1 = '{0, 0, 1, 1, 1, 2, 3, 4, 5, 6};

        a_rst = 1'b1; a_clr = 1'b0; a_in = '0; a_vin = '0; a_st = '0; a_fl = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_in = '0; b_vin = '0; b_st = '0; b_fl = '0;
        c_rst = 1'b1; c_clr = 1'b0; c_in = '0; c_vin = '0; c_st = '0; c_fl = '0;

        // ---------------- A: reset, table, saturation ----------------
        a_vin = 2'b11; a_in = {32'h55, 32'h66};
        tick();
        chk("a_rst_instr", a_out, 64'h0);
        chk("a_rst_valid", a_vout, 2'b00);
        tick();
        chk("a_rst_cnt", {a_sc, a_fc}, 16'h0);
        a_rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            a_st = tbl[v].st; a_fl = tbl[v].fl; a_vin = tbl[v].vin;
            a_clr = tbl[v].clr; a_in = tbl[v].din;
            tick();
            chk($sformatf("a_v%0d_instr", v), a_out, tbl[v].eout);
            chk($sformatf("a_v%0d_valid", v), a_vout, tbl[v].ev);
            chk($sformatf("a_v%0d_stall_cnt", v), a_sc, tbl[v].esc);
            chk($sformatf("a_v%0d_flush_cnt", v), a_fc, tbl[v].efc);
        end

        a_clr = 1'b0; a_fl = 2'b00; a_st = 2'b01;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15) chk("a_sat_at15", a_sc, 8'h0F);
        end
        chk("a_sat_stall_cnt", a_sc, 8'h0F);
        chk("a_sat_hold_instr", a_out, {32'h11, 32'hE7});
        a_clr = 1'b1;
        tick();
        chk("a_clear_with_stall", a_sc, 8'h00);
        a_clr = 1'b0;
        tick();
        chk("a_count_after_clear", a_sc, 8'h01);
        a_st = 2'b00;

        // ---------------- B: DEPTH=3 per-lane stall ----------------
        b_rst = 1'b1;
        tick();
        tick();
        chk("b_rst_valid", b_vout, 2'b00);
        b_rst = 1'b0;
        b_vin = 2'b11;
        for (int t = 1; t <= 10; t++) begin
            b_lane1 = (t <= 3) ? 32'(t) : (t <= 5) ? 32'd4 : 32'(t - 2);
            b_st = (t == 4 || t == 5) ? 2'b10 : 2'b00;
            b_in = {b_lane1, 32'(100 + t)};
            tick();
            chk($sformatf("b_t%0d_lane1", t), {b_vout[1], b_out[63:32]},
                {(t >= 3), 32'(b_exp1[t-1])});
            chk($sformatf("b_t%0d_lane0", t), {b_vout[0], b_out[31:0]},
                {(t >= 3), (t >= 3) ? 32'(100 + t - 2) : 32'h0});
        end
        chk("b_stall_cnt", b_sc, {16'd2, 16'd0});
        chk("b_flush_cnt", b_fc, 32'h0);
        b_st = 2'b00;

        // ---------------- C: lockstep and reset mid-stream ----------------
        c_rst = 1'b1;
        tick();
        tick();
        chk("c_rst_instr", c_out, {4{C_NOP}});
        chk("c_rst_valid", c_vout, 4'b0000);
        c_rst = 1'b0;
        c_vin = 4'b1111;

        c_in = cvec(1);
        tick();
        chk("c_t1_valid", c_vout, 4'b0000);
        c_in = cvec(2);
        tick();
        chk("c_t2_instr", c_out, cvec(1));
        chk("c_t2_valid", c_vout, 4'b1111);

        c_in = cvec(3); c_fl = 4'b0010;
        tick();
        chk("c_flush_instr", c_out, {C_NOP, C_NOP, C_NOP, cval(2, 0)});
        chk("c_flush_valid", c_vout, 4'b0001);
        chk("c_flush_cnt", c_fc, {8'd1, 8'd1, 8'd1, 8'd0});
        chk("c_flush_scnt", c_sc, 32'h0);

        c_in = cvec(4); c_fl = 4'b0000; c_st = 4'b1000;
        tick();
        chk("c_stall_instr", c_out, {C_NOP, C_NOP, C_NOP, cval(2, 0)});
        chk("c_stall_valid", c_vout, 4'b0001);
        chk("c_stall_cnt", c_sc, {8'd1, 8'd1, 8'd1, 8'd1});

        c_in = cvec(5); c_st = 4'b0000;
        tick();
        chk("c_t5_instr", c_out, {C_NOP, C_NOP, C_NOP, cval(3, 0)});
        chk("c_t5_valid", c_vout, 4'b0001);
        c_in = cvec(6);
        tick();
        chk("c_t6_instr", c_out, cvec(5));
        chk("c_t6_valid", c_vout, 4'b1111);
        chk("c_t6_stall_cnt", c_sc, {8'd1, 8'd1, 8'd1, 8'd1});

        c_in = cvec(7); c_st = 4'b1111; c_rst = 1'b1;
        tick();
        chk("c_midrst_instr", c_out, {4{C_NOP}});
        chk("c_midrst_valid", c_vout, 4'b0000);
        chk("c_midrst_cnt", {c_sc, c_fc}, 64'h0);
        c_rst = 1'b0; c_st = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_lane_pipe.md
Name: if_id_lane_pipe

Overview:
- Parametrised successor to the dual-issue IF/ID register: LANES independent instruction lanes, each a DEPTH-stage register chain.
- Each lane carries an instruction word and a valid bit, with per-lane stall and flush.
- Optional lockstep mode couples lanes in program order.
- Per-lane saturating stall/flush event counters support performance analysis.
- Sits between fetch and decode; the default configuration (LANES=2, DEPTH=1, LOCKSTEP=0) reproduces the existing even/odd IF/ID behaviour, plus valid bits and counters.

Parameters:
- LANES, 2, number of issue lanes; lane 0 is the oldest (even pipe).
- WIDTH, 32, instruction width in bits.
- DEPTH, 1, register stages per lane; must be ≥1.
- LOCKSTEP, 0, 1 = stalls are shared across lanes and flushes propagate to younger lanes.
- NOP_INSTR, 32'h0, instruction value loaded into every stage on reset or flush.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  LANES*WIDTH  fetched instructions; lane i occupies bits [i*WIDTH +: WIDTH].
- valid_in  in  LANES  per-lane instruction valid.
- stall  in  LANES  per-lane hold request.
- flush  in  LANES  per-lane kill request.
- instr_out  out  LANES*WIDTH  decode-side instructions, same packing as instr_in.
- valid_out  out  LANES  decode-side valid.
- stall_cnt  out  LANES*CNT_W  per-lane count of stalled cycles.
- flush_cnt  out  LANES*CNT_W  per-lane count of flush cycles.
- clear_cnt  in  1  synchronous clear of all counters.

Behaviour:
- Reset: every stage instr=NOP_INSTR, valid=0. All counters = 0. Hence after reset instr_out = NOP_INSTR replicated, valid_out = 0.
- Reset mid-operation overrides stall, flush and clear_cnt in the same cycle.
- Effective controls:
  - LOCKSTEP=0: st_e[i]=stall[i], fl_e[i]=flush[i].
  - LOCKSTEP=1: st_e[i] = OR of stall[0..LANES-1]; fl_e[i] = OR of flush[0..i], so a flush of an older lane kills all younger lanes.
- Per-lane update, in priority order:
  - fl_e=1: all DEPTH stages load NOP_INSTR with valid=0. Flush beats stall.
  - st_e=1: all stages hold their values. The input is not captured; fetch must hold instr_in itself.
  - Otherwise: stage 0 captures {valid_in, instr_in}, and stage k captures stage k-1.
- Outputs come from the last stage, registered only; there is no combinational input→output path.
- Latency: DEPTH cycles from capture to instr_out when the lane has no stalls. Each stalled cycle adds one.
- Bubbles (valid_in=0) propagate as ordinary entries; their instr field passes through unchanged.
- Counters:
  - stall_cnt[i] += 1 on each cycle with st_e=1 and fl_e=0.
  - flush_cnt[i] += 1 on each cycle with fl_e=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - clear_cnt=1 zeroes all counters. Same-cycle events are discarded, so the counter reads 0 next cycle.
  - Counters count effective (post-lockstep) events.
- Simultaneous stall and flush on a lane: flush applies and flush_cnt increments; stall_cnt does not.
- Each lane is independent when LOCKSTEP=0. Lanes may drift relative to each other; that is the caller's responsibility.

Decomposition:
- Package spu_pipe_pkg holds:
  - SPU_NOP constant (default for NOP_INSTR).
  - Typedef lane_entry_t {logic valid; logic [WIDTH-1:0] instr} via a parametrised struct macro or fixed-32 typedef.
  - Saturating-increment function.
- Sub-module if_id_lane: one lane's DEPTH-stage chain plus its two counters, taking st_e/fl_e.
- The top generates LANES instances and the lockstep control logic.

Test Plan:
- Reset/plain flow (default params): reset 2 cycles, then lane0=32'hA1, lane1=32'hB2 with valid=2'b11 → next cycle instr_out={B2,A1}, valid_out=11; during reset outputs are 0/00.
- Stall vs flush priority: assert stall[0]=1 and flush[0]=1 together for 1 cycle with lane0 holding A1 → lane0 out NOP, valid 0; flush_cnt[0]=1, stall_cnt[0]=0.
- Per-lane stall, DEPTH=3: feed 1,2,3,… on lane 1 and stall lane 1 for 2 cycles after the third input → lane 1 output sequence delayed by 2 cycles, no value lost or duplicated except held; stall_cnt[1]=2; lane 0 unaffected.
- Lockstep (LANES=4, LOCKSTEP=1): flush[1]=1 only → lanes 1,2,3 flushed and lane 0 kept; then stall[3]=1 only → all four lanes hold; stall_cnt=1 in every lane.
- Counter saturation/clear (CNT_W=4): stall lane 0 for 20 cycles → stall_cnt[0]=15. Then clear_cnt together with a stall → 0 next cycle.
- Reset mid-stream: reset asserted while DEPTH=2 pipe is full and stalled → next cycle all valid_out=0, instr_out=NOP, counters=0.
